vector_element_sequencer: RTL

VECTOR_ELEMENT_SEQUENCER -- requirements
Module: vector_element_sequencer

---
 rtl/vector_element_sequencer_if.sv | 33 +++
 rtl/vector_element_sequencer.sv | 75 +++++++
 2 files changed

// File: rtl/vector_element_sequencer_if.sv
// vector_element_sequencer_if: request, beat and status signals of the element sequencer
interface vector_element_sequencer_if #(
  parameter int VLEN      = 128,
  parameter int NUM_LANES = 2
);
  localparam int VLENB = VLEN / 8;
  localparam int VL_W  = $clog2(VLEN) + 1;
  localparam int BO_W  = $clog2(VLENB);
  logic                 in_valid;
  logic                 in_ready;
  logic [VL_W-1:0]      vl;
  logic [VL_W-1:0]      vstart;
  logic [2:0]           sew;
  logic [2:0]           lmul;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [VL_W-1:0]      out_eidx;
  logic [NUM_LANES-1:0] out_lane_en;
  logic [2:0]           out_vreg_off;
  logic [BO_W-1:0]      out_byte_off;
  logic                 out_last;
  logic                 done;
  logic                 err;
  modport master (
    output in_valid, vl, vstart, sew, lmul, flush, out_ready,
    input  in_ready, out_valid, out_eidx, out_lane_en, out_vreg_off, out_byte_off, out_last, done, err
  );
  modport slave (
    input  in_valid, vl, vstart, sew, lmul, flush, out_ready,
    output in_ready, out_valid, out_eidx, out_lane_en, out_vreg_off, out_byte_off, out_last, done, err
  );
endinterface

// File: rtl/vector_element_sequencer.sv
// vector_element_sequencer: walks vstart..vl-1 in NUM_LANES-wide beats with register/byte offsets
module vector_element_sequencer #(
  parameter int VLEN      = 128,
  parameter int NUM_LANES = 2
) (
  input logic CLK,
  input logic nRST,
  vector_element_sequencer_if.slave bus
);
  localparam int VLENB = VLEN / 8;
  localparam int VL_W  = $clog2(VLEN) + 1;
  localparam int BO_W  = $clog2(VLENB);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]      state;
  logic [VL_W-1:0] base, vl_q, vstart_q;
  logic [1:0]      sew_q;
  logic            err_q;
  logic [VL_W-1:0] epr_in, vlmax;
  logic            illegal, empty, run, last;

  assign epr_in  = VL_W'(VLENB) >> bus.sew;
  assign vlmax   = bus.lmul[2] ? epr_in >> (4'd8 - {1'b0, bus.lmul}) : epr_in << bus.lmul[1:0];
  assign illegal = bus.sew > 3'd2 || bus.lmul == 3'd4 || bus.vl > vlmax;
  assign empty   = bus.vl == '0 || bus.vstart >= bus.vl;
  assign run     = state == RUN;
  assign last    = ({1'b0, base} + (VL_W+1)'(NUM_LANES)) >= {1'b0, vl_q};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      base     <= '0;
      vl_q     <= '0;
      vstart_q <= '0;
      sew_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else if (state == IDLE && bus.in_valid) begin
        vl_q     <= bus.vl;
        vstart_q <= bus.vstart;
        sew_q    <= bus.sew[1:0];
        base     <= bus.vstart & ~VL_W'(NUM_LANES - 1);
        err_q    <= illegal;
        state    <= illegal ? IDLE : empty ? FIN : RUN;
      end else if (run && bus.out_ready) begin
        base  <= last ? base : base + VL_W'(NUM_LANES);
        state <= last ? FIN : RUN;
      end else if (state == FIN) begin
        state <= IDLE;
      end
    end
  end

  // base/EPR and (base mod EPR)<<sew both fall out of base<<sew split at the register byte width
  assign bus.in_ready     = state == IDLE;
  assign bus.out_valid    = run;
  assign bus.out_eidx     = run ? base : '0;
  assign bus.out_vreg_off = run ? 3'(({2'b00, base} << sew_q) >> BO_W) : 3'd0;
  assign bus.out_byte_off = run ? BO_W'({2'b00, base} << sew_q) : '0;
  assign bus.out_last     = run && last;
  assign bus.done         = state == FIN;
  assign bus.err          = err_q;

  always_comb begin
    bus.out_lane_en = '0;
    for (int i = 0; i < NUM_LANES; i++)
      bus.out_lane_en[i] = run && (({1'b0, base} + (VL_W+1)'(i)) >= {1'b0, vstart_q})
                               && (({1'b0, base} + (VL_W+1)'(i)) < {1'b0, vl_q});
  end
endmodule
